// File: rtl/vga_fetch_sched.sv
// vga_fetch_sched: VGA line-buffer refill scheduler; define FETCH_PREFETCH_EN to fetch ahead at the buffer low-water mark
module vga_fetch_sched #(
   parameter int BSIZE       = 2,
   parameter int AW          = 18,
   parameter int FRAME_WORDS = 153600,
   parameter int TIMEOUT     = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               frame_start,
   input  logic               clr_err,
   output logic               mem_req,
   output logic [AW-1:0]      mem_addr,
   input  logic               mem_ack,
   input  logic [BSIZE*8-1:0] mem_rdata,
   input  logic               buf_full,
   input  logic               buf_watermark,
   input  logic               need_pixel,
   output logic               buf_load,
   output logic [BSIZE*8-1:0] buf_data,
   output logic               frame_done,
   output logic               underrun,
   output logic               timeout_err,
   output logic               busy
);
   typedef enum logic [2:0] {IDLE, REQ, HOLD, LOAD, WAIT} state_t;
   state_t state, state_nx;
   logic running, hold_valid, acked, timed_out, last, trigger;
   logic [3:0] wait_cnt;
   logic [BSIZE*8-1:0] hold;
`ifdef FETCH_PREFETCH_EN
   assign trigger = buf_watermark || !buf_full;
`else
   logic unused_wm;
   assign unused_wm = buf_watermark;
   assign trigger = !buf_full;
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else if (en) state <= state_nx;
   always_comb
      state_nx = frame_start     ? REQ :
                 state == REQ    ? (acked ? HOLD : REQ) :
                 state == HOLD   ? (hold_valid && !buf_full ? LOAD : HOLD) :
                 state == LOAD   ? (last ? IDLE : WAIT) :
                 state == WAIT   ? (trigger ? REQ : WAIT) : IDLE;
   // the timeout cycle withdraws the request, so an ack seen then is ignored
   always_comb begin
      timed_out = state == REQ && wait_cnt == 4'(TIMEOUT);
      mem_req   = state == REQ && !timed_out;
      acked     = mem_req && mem_ack;
      buf_load  = state == LOAD;
      last      = mem_addr == AW'(FRAME_WORDS - 1);
      busy      = running;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         running     <= 1'b0;
         mem_addr    <= '0;
         buf_data    <= '0;
         hold        <= '0;
         hold_valid  <= 1'b0;
         wait_cnt    <= '0;
         frame_done  <= 1'b0;
         underrun    <= 1'b0;
         timeout_err <= 1'b0;
      end else if (en) begin
         frame_done  <= 1'b0;
         underrun    <= (need_pixel && !buf_full && running) || (underrun && !clr_err);
         timeout_err <= timed_out || (timeout_err && !clr_err);
         if (frame_start) begin
            running    <= 1'b1;
            mem_addr   <= '0;
            hold_valid <= 1'b0;
            wait_cnt   <= '0;
         end else case (state)
            REQ: if (acked) begin
               hold       <= mem_rdata;
               hold_valid <= 1'b1;
               wait_cnt   <= '0;
            end else wait_cnt <= timed_out ? '0 : wait_cnt + 1'b1;
            HOLD: if (hold_valid && !buf_full) begin
               buf_data   <= hold;
               hold_valid <= 1'b0;
            end
            LOAD: if (last) begin
               mem_addr   <= '0;
               frame_done <= 1'b1;
               running    <= 1'b0;
            end else mem_addr <= mem_addr + 1'b1;
            default: ;
         endcase
      end
endmodule

// File: tb/tb_vga_fetch_sched.sv
// tb_vga_fetch_sched: directed-random bench with an address counter / word queue reference
module tb_vga_fetch_sched;
   localparam int BSIZE = 2, AW = 18, FW = 4, TO = 15, DW = BSIZE * 8;
   logic clk = 0, rst = 0, en = 1, frame_start = 0, clr_err = 0, mem_ack = 0;
   logic buf_full = 0, buf_watermark = 0, need_pixel = 0;
   logic [DW-1:0] mem_rdata = '0;
   logic mem_req, buf_load, frame_done, underrun, timeout_err, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] buf_data;
   int checks = 0, errors = 0, exp_addr = 0, drops;
   logic [DW-1:0] word_q[$];
   vga_fetch_sched #(.BSIZE(BSIZE), .AW(AW), .FRAME_WORDS(FW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .en(en), .frame_start(frame_start), .clr_err(clr_err),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .buf_full(buf_full), .buf_watermark(buf_watermark), .need_pixel(need_pixel),
      .buf_load(buf_load), .buf_data(buf_data), .frame_done(frame_done),
      .underrun(underrun), .timeout_err(timeout_err), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // entered with a request outstanding for exp_addr; returns in the load cycle
   task automatic fetch_word(input logic [DW-1:0] w, input int full_cyc);
      int d;
      d = $urandom_range(0, 3);
      chk("req_on", mem_req, 1);
      chk("req_addr", mem_addr, exp_addr);
      repeat (d) begin
         tick;
         chk("req_stable", {mem_req, mem_addr}, {1'b1, AW'(exp_addr)});
      end
      mem_ack = 1; mem_rdata = w; buf_full = full_cyc > 0; word_q.push_back(w);
      tick;
      mem_ack = 0; mem_rdata = ~w;
      chk("hold_noreq", mem_req, 0);
      repeat (full_cyc) begin
         tick;
         chk("hold_noload", buf_load, 0);
      end
      buf_full = 0;
      tick;
      chk("load", buf_load, 1);
      chk("load_data", buf_data, word_q.pop_front());
   endtask
   task automatic finish_word;
      tick;
      exp_addr = (exp_addr + 1) % FW;
      chk("frame_done", frame_done, exp_addr == 0);
      chk("busy", busy, exp_addr != 0);
      chk("load_pulse", buf_load, 0);
      if (exp_addr != 0) tick;
   endtask
   initial begin
      repeat (3) tick;
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_load", buf_load, 0);
      chk("rst_data", buf_data, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_busy", busy, 0);
      rst = 1;
      tick;
      chk("idle_noreq", mem_req, 0);
      frame_start = 1; tick; frame_start = 0; exp_addr = 0;
      chk("busy_start", busy, 1);
      fetch_word(16'hA55A, 0);
      finish_word;
      for (int i = 1; i < FW; i++) begin
         fetch_word(DW'($urandom), $urandom_range(0, 3));
         finish_word;
      end
      repeat (3) begin
         tick;
         chk("idle_stays", {mem_req, frame_done, busy}, 0);
      end
      frame_start = 1; tick; frame_start = 0;
      drops = 0;
      while (mem_req && drops < 40) begin tick; drops++; end
      chk("timeout_cycles", drops, TO);
      chk("timeout_gap_addr", mem_addr, 0);
      tick;
      chk("retry", {mem_req, mem_addr}, {1'b1, AW'(0)});
      chk("timeout_err", timeout_err, 1);
      clr_err = 1; tick; clr_err = 0;
      chk("clr_timeout", timeout_err, 0);
      en = 0;
      repeat (30) tick;
      en = 1;
      chk("en_hold_req", mem_req, 1);
      chk("en_hold_err", timeout_err, 0);
      clr_err = 1;
      drops = 0;
      while (mem_req && drops < 40) begin tick; drops++; end
      chk("timeout_resume", drops, TO - 1);
      tick; clr_err = 0;
      chk("set_wins_timeout", timeout_err, 1);
      mem_ack = 1; frame_start = 1; tick; mem_ack = 0; frame_start = 0;
      chk("start_beats_ack", {mem_req, mem_addr}, {1'b1, AW'(0)});
      exp_addr = 0;
      for (int i = 0; i < 2; i++) begin
         fetch_word(DW'($urandom), $urandom_range(0, 2));
         finish_word;
      end
      chk("abort_at", mem_addr, 2);
      mem_ack = 1; mem_rdata = DW'($urandom); buf_full = 1; tick; mem_ack = 0;
      chk("abort_hold", {mem_req, buf_load}, 0);
      frame_start = 1; buf_full = 0; tick; frame_start = 0;
      chk("abort_noload", buf_load, 0);
      chk("abort_req", {mem_req, mem_addr}, {1'b1, AW'(0)});
      chk("abort_nodone", frame_done, 0);
      chk("abort_busy", busy, 1);
      exp_addr = 0;
      for (int i = 0; i < FW; i++) begin
         fetch_word(DW'($urandom), $urandom_range(0, 3));
         finish_word;
      end
      need_pixel = 1; tick;
      chk("underrun_idle", underrun, 0);
      frame_start = 1; tick; frame_start = 0; exp_addr = 0;
      chk("underrun_start", underrun, 0);
      tick;
      chk("underrun_set", underrun, 1);
      need_pixel = 0; tick;
      chk("underrun_sticky", underrun, 1);
      need_pixel = 1; clr_err = 1; tick;
      chk("set_wins_underrun", underrun, 1);
      need_pixel = 0; tick; clr_err = 0;
      chk("underrun_clr", underrun, 0);
      fetch_word(DW'($urandom), 0);
      buf_full = 1; buf_watermark = 1; tick; exp_addr = 1;
      chk("wait_noreq", mem_req, 0);
`ifdef FETCH_PREFETCH_EN
      tick;
      chk("prefetch_req", {mem_req, mem_addr}, {1'b1, AW'(exp_addr)});
`else
      repeat (3) begin
         tick;
         chk("no_prefetch", mem_req, 0);
      end
      buf_full = 0; tick;
      chk("req_after_drain", {mem_req, mem_addr}, {1'b1, AW'(exp_addr)});
`endif
      fetch_word(DW'($urandom), 2);
      buf_watermark = 0;
      finish_word;
      for (int i = 2; i < FW; i++) begin
         fetch_word(DW'($urandom), $urandom_range(0, 3));
         finish_word;
      end
      tick;
      chk("end_idle", {mem_req, busy, frame_done}, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_fetch_sched.md
Name: vga_fetch_sched

Overview:
Refill scheduler for the VGA pixel line buffer. It fetches BSIZE-byte words from framebuffer memory over a req/ack handshake and holds each word in a staging register. It pulses a one-cycle load into the pixel buffer when that buffer drains. It walks the framebuffer linearly, wraps each frame, and flags memory timeouts and pixel underruns.

Parameters:
BSIZE, 2, bytes per buffer word; the data path is BSIZE*8 bits wide.
AW, 18, framebuffer word-address width.
FRAME_WORDS, 153600, words per frame (640x480 at BSIZE=2); must be <= 2**AW.
TIMEOUT, 15, maximum cycles in REQ waiting for mem_ack; 4-bit counter, range 1..15.

Ports:
clk  in  1  pixel-domain clock
rst  in  1  reset, asynchronous, active-low
en  in  1  clock enable; when low, all state, counters and outputs hold
frame_start  in  1  one-cycle pulse at start of vertical active region
clr_err  in  1  clears the sticky error flags
mem_req  out  1  read request; held until mem_ack
mem_addr  out  AW  word address; stable while mem_req is high
mem_ack  in  1  read accepted; mem_rdata valid in the same cycle
mem_rdata  in  BSIZE*8  read data
buf_full  in  1  pixel buffer holds unread pixels
buf_watermark  in  1  pixel buffer has reached its low-water mark
need_pixel  in  1  display consumes a pixel this cycle
buf_load  out  1  one-cycle load strobe to the pixel buffer
buf_data  out  BSIZE*8  word presented with buf_load
frame_done  out  1  one-cycle pulse after the last word of a frame is loaded
underrun  out  1  sticky flag: pixel requested while the buffer is empty
timeout_err  out  1  sticky flag: memory failed to ack within TIMEOUT
busy  out  1  high while a frame is running (frame_start seen, frame not complete)

Behaviour:
- Reset values: state IDLE; running=0; mem_req=0; mem_addr=0; buf_load=0; buf_data=0; frame_done=0; underrun=0; timeout_err=0; busy=0; hold_valid=0; wait_cnt=0.
- The block only acts on cycles where en=1. It behaves identically to having no clock edge otherwise.
- State IDLE:
  - Entered after reset or after a frame completes.
  - frame_start -> mem_addr=0, running=1, state REQ.
- State REQ:
  - mem_req=1 and mem_addr held stable.
  - On mem_ack: mem_rdata is captured into the hold register, hold_valid=1, mem_req=0 on the next cycle, state HOLD.
  - If no ack arrives, wait_cnt increments each cycle. When wait_cnt==TIMEOUT:
    - mem_req drops for exactly one cycle and timeout_err is set.
    - wait_cnt clears and the request is retried at the same address.
- State HOLD:
  - Waits for buf_full==0.
  - On the cycle buf_full==0 is seen: buf_load=1 next cycle, buf_data=hold register, hold_valid=0, state LOAD.
- State LOAD (one cycle, buf_load high):
  - If mem_addr==FRAME_WORDS-1: mem_addr=0, frame_done=1 next cycle, running=0, state IDLE.
  - Otherwise mem_addr=mem_addr+1 and the state goes to WAIT.
- State WAIT:
  - Waits for the fetch trigger, then goes to REQ.
  - The trigger is defined under Optional Feature.
  - The trigger is evaluated one cycle after LOAD, which gives the buffer time to raise buf_full.
- Latency:
  - mem_ack in cycle N -> HOLD in N+1.
  - If buf_full is already 0 at N+1 -> buf_load in N+2.
- frame_start arriving while running (mid-operation):
  - The fetch is aborted, mem_req=0, hold_valid=0 and mem_addr=0.
  - The next cycle enters REQ; the old frame's data is discarded.
  - frame_done is not pulsed.
  - frame_start takes priority over mem_ack arriving in the same cycle.
- underrun: set when need_pixel=1, buf_full=0 and running=1 in the same cycle.
- Sticky flags: clr_err clears underrun and timeout_err. If clr_err and a set condition occur in the same cycle, set wins.
- Address width: mem_addr increments modulo FRAME_WORDS, never modulo 2**AW.
- busy = running.

Optional Feature:
Macro FETCH_PREFETCH_EN.
- Defined: the WAIT trigger is (buf_watermark==1 || buf_full==0). The next word is fetched while the current one drains, so that word sits ready in HOLD.
- Undefined: the WAIT trigger is buf_full==0 only. This gives a simpler memory-load profile, and underruns are expected under slow memory.

Test Plan:
- Reset, then frame_start, with memory acking 1 cycle after req and buf_full=0 -> mem_addr 0 requested, buf_load 2 cycles after ack, buf_data equals mem_rdata (e.g. 16'hA55A).
- Memory never acks, TIMEOUT=15 -> mem_req drops for 1 cycle after 15 cycles, timeout_err=1, same mem_addr retried; clr_err -> timeout_err=0.
- FRAME_WORDS=4 override, full frame run -> addresses 0,1,2,3 loaded, frame_done pulses once, busy=0, IDLE until next frame_start.
- frame_start asserted while in HOLD at mem_addr 2 -> no buf_load from the stale word, next mem_req has mem_addr=0, no frame_done.
- need_pixel=1 with buf_full=0 while running -> underrun=1 and remains 1 until clr_err.
- FETCH_PREFETCH_EN defined, buf_watermark=1 with buf_full=1 -> mem_req issued before the buffer drains, and buf_load arrives 1 cycle after buf_full falls. Undefined -> no mem_req until buf_full=0.
